// File: rtl/pll_seq_pkg.sv
// Shared state encoding, counter sizing and saturation limit for the
// PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ASSERT_RST = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        RELEASE    = 3'd3,
        RUN        = 3'd4,
        LOST       = 3'd5,
        FAULT      = 3'd6
    } pll_state_t;

    localparam logic [7:0] LOCK_LOSS_SAT = 8'hFF;

    // One shared phase counter covers every timed state, so size it for the longest.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        m = (b > m) ? b : m;
        m = (c > m) ? c : m;
        m = (d > m) ? d : m;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous status bits, with a synchronous
// active-high clear.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;

    // Capture stage followed by the resolved output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= {WIDTH{1'b0}};
            q      <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, qualifies lock, and releases downstream domain resets
// in order; retries lock a bounded number of times before declaring a fault.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int NUM_DOMAINS         = 3,
    parameter int STAGE_GAP_CYCLES    = 64,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                               refclk,
    input  logic                               rst,
    input  logic                               pll_locked,
    input  logic                               soft_reset_req,
    output logic                               pll_rst,
    output logic [NUM_DOMAINS-1:0]             domain_rst,
    output logic                               ready,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [7:0]                         lock_loss_count
);

    localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                     LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES);
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0]       CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]       RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]       TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]       STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]       GAP_LAST = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [RTY_W-1:0]       RTY_ZERO = {RTY_W{1'b0}};
    localparam logic [RTY_W-1:0]       RTY_ONE  = RTY_W'(1'b1);
    localparam logic [RTY_W-1:0]       RTY_MAX  = RTY_W'(MAX_RETRIES);
    localparam logic [IDX_W-1:0]       IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]       IDX_ONE  = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] DOM_ALL  = {NUM_DOMAINS{1'b1}};

    pll_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic             lk_s;
    logic [RTY_W-1:0] retry_nxt_s;
    logic [7:0]       loss_inc_s;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk_s)
    );

    assign retry_nxt_s = retry_count + RTY_ONE;
    assign loss_inc_s  = (lock_loss_count == LOCK_LOSS_SAT) ? lock_loss_count
                                                            : lock_loss_count + 8'd1;

    // Sequencer state, shared phase counter and all registered outputs
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r         <= ASSERT_RST;
            cnt_r           <= CNT_ZERO;
            idx_r           <= IDX_ZERO;
            pll_rst         <= 1'b1;
            domain_rst      <= DOM_ALL;
            ready           <= 1'b0;
            fault           <= 1'b0;
            retry_count     <= RTY_ZERO;
            lock_loss_count <= 8'd0;
        end else if (soft_reset_req) begin
            state_r     <= ASSERT_RST;
            cnt_r       <= CNT_ZERO;
            idx_r       <= IDX_ZERO;
            pll_rst     <= 1'b1;
            domain_rst  <= DOM_ALL;
            ready       <= 1'b0;
            fault       <= 1'b0;
            retry_count <= RTY_ZERO;
        end else begin
            case (state_r)
                ASSERT_RST: begin
                    if (cnt_r == RST_LAST) begin
                        state_r <= WAIT_LOCK;
                        cnt_r   <= CNT_ZERO;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                WAIT_LOCK: begin
                    if (lk_s) begin
                        state_r <= STABLE;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == TMO_LAST) begin
                        retry_count <= retry_nxt_s;
                        cnt_r       <= CNT_ZERO;
                        pll_rst     <= 1'b1;
                        if (retry_nxt_s == RTY_MAX) begin
                            state_r <= FAULT;
                            fault   <= 1'b1;
                        end else begin
                            state_r <= ASSERT_RST;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                STABLE: begin
                    if (!lk_s) begin
                        state_r <= WAIT_LOCK;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == STB_LAST) begin
                        state_r       <= RELEASE;
                        cnt_r         <= CNT_ZERO;
                        idx_r         <= IDX_ZERO;
                        domain_rst[0] <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (!lk_s) begin
                        state_r         <= LOST;
                        cnt_r           <= CNT_ZERO;
                        domain_rst      <= DOM_ALL;
                        ready           <= 1'b0;
                        lock_loss_count <= loss_inc_s;
                    end else if (idx_r == IDX_LAST) begin
                        state_r     <= RUN;
                        cnt_r       <= CNT_ZERO;
                        ready       <= 1'b1;
                        retry_count <= RTY_ZERO;
                    end else if (cnt_r == GAP_LAST) begin
                        // Each gap expiry opens the next domain in order
                        idx_r                        <= idx_r + IDX_ONE;
                        domain_rst[idx_r + IDX_ONE]  <= 1'b0;
                        cnt_r                        <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                RUN: begin
                    if (!lk_s) begin
                        state_r         <= LOST;
                        cnt_r           <= CNT_ZERO;
                        domain_rst      <= DOM_ALL;
                        ready           <= 1'b0;
                        lock_loss_count <= loss_inc_s;
                    end else begin
                        state_r <= RUN;
                    end
                end
                LOST: begin
                    state_r <= ASSERT_RST;
                    cnt_r   <= CNT_ZERO;
                    pll_rst <= 1'b1;
                end
                FAULT: begin
                    pll_rst    <= 1'b1;
                    domain_rst <= DOM_ALL;
                    ready      <= 1'b0;
                    fault      <= 1'b1;
                end
                default: begin
                    state_r    <= ASSERT_RST;
                    cnt_r      <= CNT_ZERO;
                    idx_r      <= IDX_ZERO;
                    pll_rst    <= 1'b1;
                    domain_rst <= DOM_ALL;
                    ready      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: bring-up, lock flicker, lock loss,
// lock timeout to fault, counter saturation, soft-reset priority, mid-release reset.
module tb_pll_reset_sequencer;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       soft_reset_req;
    logic       pll_rst;
    logic [2:0] domain_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_count;

    int checks   = 0;
    int failures = 0;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (100),
        .LOCK_STABLE_CYCLES  (8),
        .NUM_DOMAINS         (3),
        .STAGE_GAP_CYCLES    (4),
        .MAX_RETRIES         (2)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .pll_locked      (pll_locked),
        .soft_reset_req  (soft_reset_req),
        .pll_rst         (pll_rst),
        .domain_rst      (domain_rst),
        .ready           (ready),
        .fault           (fault),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    initial begin
        #600000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            0:       return {31'd0, pll_rst};
            1:       return {31'd0, ready};
            2:       return {29'd0, domain_rst};
            default: return 32'd0;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input logic [31:0] val, input int budget);
        logic [31:0] obs;
        obs = sample(sel);
        for (int k = 0; k < budget && obs !== val; k++) begin
            tick(1);
            obs = sample(sel);
        end
        check(tag, obs, val);
    endtask

    initial begin
        rst = 1'b1;
        pll_locked = 1'b0;
        soft_reset_req = 1'b0;
        tick(3);
        check("rst_pll_rst", pll_rst, 1'b1);
        check("rst_domain", domain_rst, 3'b111);
        check("rst_ready", ready, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_retry", retry_count, 2'd0);
        check("rst_llc", lock_loss_count, 8'd0);

        // Normal bring-up: pll_rst held 4 cycles, lock 10 cycles later
        rst = 1'b0;
        tick(3);  check("up_pll_rst_held", pll_rst, 1'b1);
        tick(1);  check("up_pll_rst_fall", pll_rst, 1'b0);
        tick(10); check("up_wait_dom", domain_rst, 3'b111);
        pll_locked = 1'b1;
        tick(10); check("up_dom_before", domain_rst, 3'b111);
        tick(1);  check("up_dom_110", domain_rst, 3'b110);
        tick(3);  check("up_dom_110_hold", domain_rst, 3'b110);
        tick(1);  check("up_dom_100", domain_rst, 3'b100);
        tick(4);  check("up_dom_000", domain_rst, 3'b000);
        check("up_ready_early", ready, 1'b0);
        tick(1);  check("up_ready", ready, 1'b1);
        check("up_retry", retry_count, 2'd0);
        check("up_fault", fault, 1'b0);

        // Soft reset from RUN, then a 3-cycle lock flicker in STABLE
        pll_locked = 1'b0;
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        check("sr_ready", ready, 1'b0);
        check("sr_domain", domain_rst, 3'b111);
        check("sr_pll_rst", pll_rst, 1'b1);
        check("sr_llc", lock_loss_count, 8'd0);
        tick(4);  check("fl_pll_rst_fall", pll_rst, 1'b0);
        pll_locked = 1'b1;
        tick(5);
        pll_locked = 1'b0;
        tick(3);
        pll_locked = 1'b1;
        check("fl_no_retry_pulse", pll_rst, 1'b0);
        tick(3);  check("fl_dom_orig_deadline", domain_rst, 3'b111);
        tick(7);  check("fl_dom_before", domain_rst, 3'b111);
        check("fl_retry", retry_count, 2'd0);
        tick(1);  check("fl_dom_110", domain_rst, 3'b110);
        tick(9);  check("fl_ready", ready, 1'b1);
        check("fl_dom_000", domain_rst, 3'b000);

        // Lock loss in RUN: edge n is the current edge
        tick(2);
        pll_locked = 1'b0;
        tick(2);  check("ll_ready_n2", ready, 1'b1);
        tick(1);  check("ll_domain_n3", domain_rst, 3'b111);
        check("ll_ready_n3", ready, 1'b0);
        check("ll_llc_n3", lock_loss_count, 8'd1);
        tick(1);  check("ll_pll_rst_n4", pll_rst, 1'b1);
        tick(3);  check("ll_pll_rst_n7", pll_rst, 1'b1);
        tick(1);  check("ll_pll_rst_n8", pll_rst, 1'b0);
        pll_locked = 1'b1;
        tick(19); check("ll_ready_pre", ready, 1'b0);
        check("ll_dom_000", domain_rst, 3'b000);
        tick(1);  check("ll_ready_again", ready, 1'b1);
        check("ll_llc_keep", lock_loss_count, 8'd1);

        // Soft reset sampled in the same cycle the FSM sees the loss
        pll_locked = 1'b0;
        tick(2);  check("co_ready_m2", ready, 1'b1);
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        check("co_llc", lock_loss_count, 8'd1);
        check("co_ready", ready, 1'b0);
        check("co_pll_rst", pll_rst, 1'b1);
        check("co_domain", domain_rst, 3'b111);

        // Never lock: two timeouts then FAULT
        tick(4);  check("nl_pll_rst_fall", pll_rst, 1'b0);
        tick(99); check("nl_pre_to1_pll", pll_rst, 1'b0);
        check("nl_pre_to1_retry", retry_count, 2'd0);
        tick(1);  check("nl_to1_pll", pll_rst, 1'b1);
        check("nl_to1_retry", retry_count, 2'd1);
        check("nl_to1_fault", fault, 1'b0);
        tick(4);  check("nl_rearm", pll_rst, 1'b0);
        tick(99); check("nl_pre_to2_fault", fault, 1'b0);
        tick(1);  check("nl_fault", fault, 1'b1);
        check("nl_retry2", retry_count, 2'd2);
        check("nl_pll_rst", pll_rst, 1'b1);
        check("nl_domain", domain_rst, 3'b111);
        check("nl_ready", ready, 1'b0);
        tick(5);  check("nl_fault_hold", fault, 1'b1);
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        check("nl_sr_fault", fault, 1'b0);
        check("nl_sr_retry", retry_count, 2'd0);
        check("nl_sr_pll_rst", pll_rst, 1'b1);
        tick(3);  check("nl_sr_pll_held", pll_rst, 1'b1);
        tick(1);  check("nl_sr_pll_fall", pll_rst, 1'b0);

        // Repeated RUN lock losses drive the counter into saturation
        for (int i = 0; i < 256; i++) begin
            wait_for("sat_wait_lock", 0, 32'd0, 10);
            pll_locked = 1'b1;
            wait_for("sat_ready", 1, 32'd1, 40);
            pll_locked = 1'b0;
            wait_for("sat_lost", 1, 32'd0, 10);
            if (i == 252) check("sat_llc_254", lock_loss_count, 8'd254);
            if (i == 253) check("sat_llc_255", lock_loss_count, 8'd255);
            wait_for("sat_pll_rst", 0, 32'd1, 5);
        end
        check("sat_llc_final", lock_loss_count, 8'd255);

        // Synchronous reset in the middle of RELEASE
        wait_for("mr_wait_lock", 0, 32'd0, 10);
        pll_locked = 1'b1;
        wait_for("mr_release", 2, 32'd6, 30);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("mr_pll_rst", pll_rst, 1'b1);
        check("mr_domain", domain_rst, 3'b111);
        check("mr_ready", ready, 1'b0);
        check("mr_fault", fault, 1'b0);
        check("mr_retry", retry_count, 2'd0);
        check("mr_llc", lock_loss_count, 8'd0);
        rst = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Sits directly downstream of the system PLL and runs on the 50 MHz reference clock. It drives the PLL reset, watches the PLL lock indication, and releases resets to the downstream 143 MHz domains in a fixed order once lock has been stable long enough. It detects loss of lock, re-locks with bounded retries, and flags a fault when the PLL will not lock.

Parameters:
RST_PULSE_CYCLES, 16, refclk cycles that pll_rst is held high per reset attempt (>=1)
LOCK_TIMEOUT_CYCLES, 50000, refclk cycles allowed for lock after pll_rst deasserts (1 ms)
LOCK_STABLE_CYCLES, 1024, consecutive locked cycles required before domain release
NUM_DOMAINS, 3, number of sequenced domain resets
STAGE_GAP_CYCLES, 64, refclk cycles between successive domain releases
MAX_RETRIES, 3, lock timeouts tolerated before entering FAULT

Ports:
refclk  in  1  reference clock, 50 MHz
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL locked, asynchronous to refclk
soft_reset_req  in  1  single-cycle request to restart the full sequence
pll_rst  out  1  reset to the PLL, active-high
domain_rst  out  NUM_DOMAINS  per-domain resets, active-high, bit 0 released first
ready  out  1  all domains released, PLL locked
fault  out  1  lock failed MAX_RETRIES times
retry_count  out  $clog2(MAX_RETRIES+1)  lock timeouts in the current sequence
lock_loss_count  out  8  lock losses seen in RUN; saturates at 255

Behaviour:
- Clock and reset: one clock, refclk. Reset rst is synchronous and active-high.
- Reset values while rst is high:
  - state=ASSERT_RST, pll_rst=1, domain_rst=all 1, ready=0, fault=0.
  - retry_count=0, lock_loss_count=0, internal counters 0.
- Lock synchronisation: pll_locked passes through a 2-FF synchroniser. Only the synchronised value (lk) is used.
- A single shared down/up counter serves every timed state. Its width is the $clog2 of the largest parameter. It reloads on every state transition.
- State machine:
  - ASSERT_RST:
    - pll_rst=1, domain_rst=all 1, ready=0.
    - After RST_PULSE_CYCLES cycles, go to WAIT_LOCK.
  - WAIT_LOCK:
    - pll_rst=0.
    - lk=1: go to STABLE.
    - Counter reaches LOCK_TIMEOUT_CYCLES with lk=0: retry_count++.
    - If the new retry_count==MAX_RETRIES, go to FAULT; otherwise go to ASSERT_RST.
  - STABLE:
    - lk=0: return to WAIT_LOCK with the timeout restarted. Not counted as a retry.
    - LOCK_STABLE_CYCLES consecutive lk=1 cycles: go to RELEASE with index i=0.
  - RELEASE:
    - Clear domain_rst[i].
    - After STAGE_GAP_CYCLES, i++.
    - The cycle after domain_rst[NUM_DOMAINS-1] clears, go to RUN.
    - lk=0 during RELEASE: treated as a lock loss (see LOST).
  - RUN:
    - ready=1; retry_count cleared on entry.
    - lk=0: go to LOST.
  - LOST:
    - One cycle. domain_rst=all 1, ready=0, lock_loss_count++ (saturating), then ASSERT_RST.
  - FAULT:
    - fault=1, pll_rst=1, domain_rst=all 1.
    - Held until rst or soft_reset_req.
- Lock-loss latency: pll_locked falls at edge n; lk falls at n+2. domain_rst goes all 1 and ready goes 0 at edge n+3 (LOST entered).
- All outputs are registered; no combinational paths from inputs to outputs.
- soft_reset_req, from any state:
  - Next state ASSERT_RST, domain_rst=all 1, ready=0, fault=0, retry_count=0.
  - lock_loss_count is kept.
- Priority: rst > soft_reset_req > lock loss/timeout > normal progress. A soft_reset_req in the same cycle as a RUN lock loss does not increment lock_loss_count.
- A lk glitch shorter than the sync depth may be missed; the design accepts this.

Decomposition:
- Package pll_seq_pkg holds:
  - state enum {ASSERT_RST, WAIT_LOCK, STABLE, RELEASE, RUN, LOST, FAULT}
  - the counter-width function
  - the lock_loss_count saturation constant (8'hFF)
- Sub-module sync_2ff: a parameterisable-width two-flop synchroniser with sync active-high reset. It is also reused for other asynchronous status bits in the design.

Test Plan:
- Bench parameters: RST_PULSE=4, TIMEOUT=100, STABLE=8, GAP=4, NUM_DOMAINS=3, MAX_RETRIES=2.
- Normal bring-up: rst low, pll_locked rises 10 cycles after pll_rst falls.
  -> domain_rst steps 3'b111 -> 3'b110 -> 3'b100 -> 3'b000 at 4-cycle spacing; ready=1; retry_count=0.
- Lock flicker in STABLE: pll_locked drops for 3 cycles after 5 locked cycles.
  -> Returns to WAIT_LOCK; retry_count stays 0; the full 8-cycle stability is re-required.
- Lock loss in RUN: drop pll_locked at edge n.
  -> At n+3, domain_rst=3'b111, ready=0, lock_loss_count=1, pll_rst=1 for 4 cycles; full re-sequence follows.
- Never lock: hold pll_locked=0.
  -> Two 100-cycle timeouts, then fault=1, retry_count=2, pll_rst=1, domain_rst=3'b111.
  -> soft_reset_req clears fault and restarts ASSERT_RST.
- Saturation and priority:
  - Force 256 RUN lock losses -> lock_loss_count=255.
  - soft_reset_req coincident with a lock loss -> count unchanged.
  - rst mid-RELEASE -> all outputs at reset values on the next edge.
